// File: rtl/frame_fetch.sv
// frame_fetch: DDR2 frame-buffer read initiator feeding a prefetch FIFO for the pixel pipeline.
// Define FRAME_FETCH_UNDERRUN_EN to add the underrun flag and saturating underrun counter.
module frame_fetch #(
    parameter logic [24:0] BASE_ADDR = 25'h0000000,
    parameter logic [9:0] XFR_LEN = 10'h200,
    parameter logic [15:0] XFRS_PER_FRAME = 16'd600,
    parameter int FIFO_DEPTH = 2048
) (
    input logic clk0,
    input logic rst0,
    input logic enable,
    input logic frame_start,
    output logic rd_mem_req,
    output logic [24:0] rd_mem_addr,
    output logic [9:0] rd_xfr_len,
    input logic rd_mem_grant,
    input logic [31:0] rd_data,
    input logic rd_data_valid,
    input logic pix_rd_en,
    output logic [31:0] pix_data,
    output logic pix_valid,
    output logic pix_empty,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic frame_done,
    output logic err_overflow
`ifdef FRAME_FETCH_UNDERRUN_EN
    ,
    output logic underrun,
    output logic [15:0] underrun_cnt
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, DATA = 2'd2, DRAIN = 2'd3;
    logic [1:0] state;
    logic [15:0] xfr_cnt;
    logic [9:0] beat_cnt;
    logic start_pend;
    logic [31:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [LW-1:0] space;
    logic last_beat, wr, full, push, pop, flush, restart;
    assign rd_mem_req = state == REQ;
    assign rd_xfr_len = XFR_LEN;
    assign pix_empty = fifo_level == '0;
    assign full = fifo_level == LW'(FIFO_DEPTH);
    assign space = LW'(FIFO_DEPTH) - fifo_level;
    assign last_beat = rd_data_valid && beat_cnt + 10'd1 == XFR_LEN;
    assign wr = state == DATA && rd_data_valid && !frame_start;
    assign push = wr && !full;
    assign pop = pix_rd_en && !pix_empty;
    // an aborted request ends on its final (discarded) beat, then the frame restarts
    assign restart = (state == DRAIN || (state == DATA && frame_start)) && last_beat;
    assign flush = restart || (frame_start && (state == IDLE || state == REQ));
    always_ff @(posedge clk0) begin
        if (rst0) begin
            state <= IDLE;
            rd_mem_addr <= BASE_ADDR;
            xfr_cnt <= '0;
            beat_cnt <= '0;
            start_pend <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if ((state == DATA || state == DRAIN) && rd_data_valid)
                beat_cnt <= beat_cnt + 10'd1;
            if (restart || (frame_start && state == IDLE)) begin
                state <= IDLE;
                rd_mem_addr <= BASE_ADDR;
                xfr_cnt <= '0;
            end else if (state == IDLE) begin
                if (enable && space >= LW'(XFR_LEN))
                    state <= REQ;
            end else if (state == REQ) begin
                if (rd_mem_grant) begin
                    beat_cnt <= '0;
                    state <= (start_pend || frame_start) ? DRAIN : DATA;
                    start_pend <= 1'b0;
                end else if (frame_start) begin
                    start_pend <= 1'b1;
                end
            end else if (state == DATA) begin
                if (frame_start) begin
                    state <= DRAIN;
                end else if (last_beat) begin
                    state <= IDLE;
                    if (xfr_cnt + 16'd1 == XFRS_PER_FRAME) begin
                        rd_mem_addr <= BASE_ADDR;
                        xfr_cnt <= '0;
                        frame_done <= 1'b1;
                    end else begin
                        rd_mem_addr <= rd_mem_addr + (25'(XFR_LEN) << 3);
                        xfr_cnt <= xfr_cnt + 16'd1;
                    end
                end
            end
        end
    end
    always_ff @(posedge clk0) begin
        if (rst0) begin
            wptr <= '0;
            rptr <= '0;
            fifo_level <= '0;
            pix_data <= '0;
            pix_valid <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            pix_valid <= pop && !flush;
            if (pop && !flush)
                pix_data <= mem[rptr];
            if (flush) begin
                wptr <= '0;
                rptr <= '0;
                fifo_level <= '0;
            end else begin
                if (push)
                    wptr <= wptr + 1'b1;
                if (pop)
                    rptr <= rptr + 1'b1;
                fifo_level <= fifo_level + LW'(push) - LW'(pop);
            end
            if ((wr && full) || (rd_data_valid && (state == IDLE || state == REQ)))
                err_overflow <= 1'b1;
        end
    end
    always_ff @(posedge clk0) begin
        if (push)
            mem[wptr] <= rd_data;
    end
`ifdef FRAME_FETCH_UNDERRUN_EN
    always_ff @(posedge clk0) begin
        if (rst0) begin
            underrun <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            if (frame_start)
                underrun <= 1'b0;
            else if (pix_rd_en && pix_empty)
                underrun <= 1'b1;
            if (pix_rd_en && pix_empty && underrun_cnt != 16'hFFFF)
                underrun_cnt <= underrun_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_frame_fetch.sv
// tb_frame_fetch: directed checks of frame_fetch with XFR_LEN=4, FIFO_DEPTH=8, XFRS_PER_FRAME=2.
module tb_frame_fetch;
    localparam logic [24:0] BASE = 25'h0123400;
    logic clk0 = 1'b0;
    logic rst0, enable, frame_start, rd_mem_grant, rd_data_valid, pix_rd_en;
    logic [31:0] rd_data;
    logic rd_mem_req, pix_valid, pix_empty, frame_done, err_overflow;
    logic [24:0] rd_mem_addr;
    logic [9:0] rd_xfr_len;
    logic [31:0] pix_data;
    logic [3:0] fifo_level;
`ifdef FRAME_FETCH_UNDERRUN_EN
    logic underrun;
    logic [15:0] underrun_cnt;
`endif
    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] exp_pix [8] = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66, 32'h77, 32'h88};

    frame_fetch #(
        .BASE_ADDR(BASE),
        .XFR_LEN(10'd4),
        .XFRS_PER_FRAME(16'd2),
        .FIFO_DEPTH(8)
    ) dut (
        .clk0(clk0),
        .rst0(rst0),
        .enable(enable),
        .frame_start(frame_start),
        .rd_mem_req(rd_mem_req),
        .rd_mem_addr(rd_mem_addr),
        .rd_xfr_len(rd_xfr_len),
        .rd_mem_grant(rd_mem_grant),
        .rd_data(rd_data),
        .rd_data_valid(rd_data_valid),
        .pix_rd_en(pix_rd_en),
        .pix_data(pix_data),
        .pix_valid(pix_valid),
        .pix_empty(pix_empty),
        .fifo_level(fifo_level),
        .frame_done(frame_done),
        .err_overflow(err_overflow)
`ifdef FRAME_FETCH_UNDERRUN_EN
        ,
        .underrun(underrun),
        .underrun_cnt(underrun_cnt)
`endif
    );

    always #5 clk0 = ~clk0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk0);
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!rd_mem_req && n < 20) begin
            @(negedge clk0);
            n++;
        end
        check(tag, 32'(rd_mem_req), 32'd1);
    endtask

    task automatic grant();
        rd_mem_grant = 1'b1;
        step(1);
        rd_mem_grant = 1'b0;
    endtask

    task automatic beat(input logic [31:0] d);
        rd_data = d;
        rd_data_valid = 1'b1;
        step(1);
        rd_data_valid = 1'b0;
    endtask

    task automatic pulse_start();
        frame_start = 1'b1;
        step(1);
        frame_start = 1'b0;
    endtask

    initial begin
        rst0 = 1'b1;
        enable = 1'b0;
        frame_start = 1'b0;
        rd_mem_grant = 1'b0;
        rd_data_valid = 1'b0;
        rd_data = '0;
        pix_rd_en = 1'b0;
        step(2);
        check("rst_req", 32'(rd_mem_req), 32'd0);
        check("rst_addr", 32'(rd_mem_addr), 32'(BASE));
        check("rst_empty", 32'(pix_empty), 32'd1);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_pix", pix_data, 32'd0);
        check("rst_pvalid", 32'(pix_valid), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_err", 32'(err_overflow), 32'd0);
        rst0 = 1'b0;
        enable = 1'b1;
        wait_req("req1");
        check("req1_addr", 32'(rd_mem_addr), 32'(BASE));
        check("req1_len", 32'(rd_xfr_len), 32'd4);
        grant();
        check("req1_drop", 32'(rd_mem_req), 32'd0);
        for (int i = 0; i < 4; i++) beat(exp_pix[i]);
        check("lvl_after1", 32'(fifo_level), 32'd4);
        wait_req("req2");
        check("req2_addr", 32'(rd_mem_addr), 32'(BASE + 25'h20));
        grant();
        for (int i = 4; i < 8; i++) beat(exp_pix[i]);
        check("done_pulse", 32'(frame_done), 32'd1);
        check("lvl_full", 32'(fifo_level), 32'd8);
        step(1);
        check("done_once", 32'(frame_done), 32'd0);
        check("wrap_addr", 32'(rd_mem_addr), 32'(BASE));
        step(3);
        check("no_req_full", 32'(rd_mem_req), 32'd0);
        for (int i = 0; i < 8; i++) begin
            pix_rd_en = 1'b1;
            step(1);
            check($sformatf("pop%0d_data", i), pix_data, exp_pix[i]);
            check($sformatf("pop%0d_valid", i), 32'(pix_valid), 32'd1);
        end
        pix_rd_en = 1'b0;
        step(1);
        check("pop_end_valid", 32'(pix_valid), 32'd0);
        check("pop_end_empty", 32'(pix_empty), 32'd1);
        check("req3_up", 32'(rd_mem_req), 32'd1);
        check("req3_addr", 32'(rd_mem_addr), 32'(BASE));
        grant();
        for (int i = 1; i <= 4; i++) beat(32'(i));
        wait_req("req4");
        check("req4_addr", 32'(rd_mem_addr), 32'(BASE + 25'h20));
        grant();
        beat(32'hA1);
        beat(32'hA2);
        pulse_start();
        beat(32'hA3);
        beat(32'hA4);
        check("drain_level", 32'(fifo_level), 32'd0);
        check("drain_empty", 32'(pix_empty), 32'd1);
        wait_req("req5");
        check("req5_addr", 32'(rd_mem_addr), 32'(BASE));
        enable = 1'b0;
        grant();
        for (int i = 1; i <= 4; i++) beat(32'(i));
        step(2);
        check("idle_noreq", 32'(rd_mem_req), 32'd0);
        check("idle_addr", 32'(rd_mem_addr), 32'(BASE + 25'h20));
        check("err_before", 32'(err_overflow), 32'd0);
        beat(32'hDEAD);
        check("err_set", 32'(err_overflow), 32'd1);
        check("err_level", 32'(fifo_level), 32'd4);
        step(3);
        check("err_sticky", 32'(err_overflow), 32'd1);
        pulse_start();
        check("idle_fs_level", 32'(fifo_level), 32'd0);
        check("idle_fs_addr", 32'(rd_mem_addr), 32'(BASE));
        check("err_keep", 32'(err_overflow), 32'd1);
        pix_rd_en = 1'b1;
        step(3);
        pix_rd_en = 1'b0;
        check("empty_pop_valid", 32'(pix_valid), 32'd0);
        check("empty_pop_level", 32'(fifo_level), 32'd0);
`ifdef FRAME_FETCH_UNDERRUN_EN
        check("underrun_set", 32'(underrun), 32'd1);
        check("underrun_cnt", 32'(underrun_cnt), 32'd3);
        pulse_start();
        check("underrun_clr", 32'(underrun), 32'd0);
        check("underrun_cnt_keep", 32'(underrun_cnt), 32'd3);
`endif
        rst0 = 1'b1;
        step(1);
        rst0 = 1'b0;
        check("err_rst", 32'(err_overflow), 32'd0);
        check("rst2_addr", 32'(rd_mem_addr), 32'(BASE));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
